// File: rtl/uart_rx_p_if.sv
// Bundles the receiver's configuration, serial line and output handshake.
interface uart_rx_p_if #(
  parameter int unsigned DIV_W = 16
);
  logic             uart_en;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_len;
  logic             stop2;
  logic             par_en;
  logic             par_odd;
  logic             rx;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             par_err;
  logic             overrun;
  logic             busy;

  modport master (
    output uart_en, baud_div, data_len, stop2, par_en, par_odd, rx, rx_ready,
    input  rx_data, rx_valid, frame_err, par_err, overrun, busy
  );

  modport slave (
    input  uart_en, baud_div, data_len, stop2, par_en, par_odd, rx, rx_ready,
    output rx_data, rx_valid, frame_err, par_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_p.sv
// Oversampling UART receiver with a one-deep output register.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_p #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned OSR   = 16
) (
  input  logic       clock,
  input  logic       resetn,
  uart_rx_p_if.slave bus
);
  localparam int unsigned SAMP_W = $clog2(OSR);
  localparam logic [SAMP_W-1:0] SMP_A    = SAMP_W'(OSR / 2 - 1);
  localparam logic [SAMP_W-1:0] SMP_B    = SAMP_W'(OSR / 2);
  localparam logic [SAMP_W-1:0] SMP_C    = SAMP_W'(OSR / 2 + 1);
  localparam logic [SAMP_W-1:0] SMP_LAST = SAMP_W'(OSR - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             r_state;
  logic               r_busy;
  logic               r_sync1, r_sync2, r_rx_prev;
  logic [DIV_W-1:0]   r_tick_cnt;
  logic [SAMP_W-1:0]  r_samp_cnt;
  logic               r_smp0, r_smp1;
  logic [3:0]         r_bit_cnt;
  logic               r_stop_cnt;
  logic [1:0]         r_len;
  logic               r_stop2;
  logic [7:0]         r_shift;
  logic               r_ferr;
  logic               r_done;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_overrun;
`ifdef UART_RX_PARITY_EN
  logic               r_par_en, r_par_odd;
  logic               r_perr;
  logic               r_par_err;
`endif

  logic       w_tick, w_start, w_decide, w_bit_end, w_bit;
  logic [3:0] w_nbits;

  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == bus.baud_div);
  assign w_start   = (r_state == S_IDLE) && bus.uart_en && r_rx_prev && !r_sync2;
  assign w_decide  = w_tick && (r_samp_cnt == SMP_C);
  assign w_bit_end = w_tick && (r_samp_cnt == SMP_LAST);
  assign w_bit     = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
  assign w_nbits   = 4'(r_len) + 4'd5;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Sample-tick divider; parked at zero while idle.
  always_ff @(posedge clock) begin
    if (!resetn || r_state == S_IDLE || w_tick) r_tick_cnt <= '0;
    else                                         r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Frame FSM: sample counting, majority vote, shifting and line checks.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_samp_cnt <= '0;
      r_smp0     <= 1'b1;
      r_smp1     <= 1'b1;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_len      <= '0;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (!bus.uart_en) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        if (w_tick) begin
          r_samp_cnt <= (r_samp_cnt == SMP_LAST) ? '0 : r_samp_cnt + 1'b1;
          if (r_samp_cnt == SMP_A) r_smp0 <= r_sync2;
          if (r_samp_cnt == SMP_B) r_smp1 <= r_sync2;
        end
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state    <= S_START;
              r_busy     <= 1'b1;
              r_len      <= bus.data_len;
              r_stop2    <= bus.stop2;
              r_samp_cnt <= '0;
              r_bit_cnt  <= '0;
              r_stop_cnt <= 1'b0;
              r_shift    <= '0;
              r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_par_en   <= bus.par_en;
              r_par_odd  <= bus.par_odd;
              r_perr     <= 1'b0;
`endif
            end
          end
          S_START: begin
            if (w_decide && w_bit) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (w_bit_end) begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_decide) begin
              r_shift[r_bit_cnt[2:0]] <= w_bit;
              r_bit_cnt               <= r_bit_cnt + 4'd1;
            end
            if (w_bit_end && r_bit_cnt == w_nbits) begin
`ifdef UART_RX_PARITY_EN
              r_state <= r_par_en ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (w_decide)  r_perr  <= ((^r_shift) ^ w_bit) != r_par_odd;
            if (w_bit_end) r_state <= S_STOP;
          end
`endif
          S_STOP: begin
            // Leave at mid-bit of the last stop bit so a prompt next start edge is seen.
            if (w_decide) begin
              if (!w_bit) r_ferr <= 1'b1;
              if (r_stop_cnt == r_stop2) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_stop_cnt <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else if (r_done) begin
      r_rx_data   <= r_shift;
      r_rx_valid  <= 1'b1;
      r_frame_err <= r_ferr;
      r_overrun   <= r_rx_valid && !bus.rx_ready;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= r_perr;
`endif
    end else if (r_rx_valid && bus.rx_ready) begin
      r_rx_valid  <= 1'b0;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.par_err   = r_par_err;
`else
  assign bus.par_err   = 1'b0;
  logic  w_unused_par;
  assign w_unused_par  = bus.par_en ^ bus.par_odd;
`endif
endmodule

// File: tb/tb_uart_rx_p.sv
// Bench for uart_rx_p: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_rx_p;
  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } word_t;

  logic  clock;
  logic  resetn;
  int    n_cmp = 0;
  int    n_err = 0;
  int    bit_cyc = 864;
  word_t got_q[$];

  uart_rx_p_if #(.DIV_W(16)) bus ();
  uart_rx_p #(.DIV_W(16), .OSR(16)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records each word at the cycle it is handed over.
  always @(negedge clock)
    if (resetn && bus.rx_valid && bus.rx_ready)
      got_q.push_back('{bus.rx_data, bus.frame_err, bus.par_err, bus.overrun});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_baud(input int bd);
    bus.baud_div = 16'(bd);
    bit_cyc      = (bd + 1) * 16;
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    tick(bit_cyc);
  endtask

  function automatic bit par_on(input bit pe);
`ifdef UART_RX_PARITY_EN
    return pe;
`else
    return 1'b0;
`endif
  endfunction

  // Expected word from frame contents: masked data, line errors, overrun.
  function automatic word_t model(input logic [7:0] d, input int len, input bit pe,
                                  input bit bad_stop, input bit bad_par, input bit ov);
    word_t w;
    logic [7:0] mask;
    mask = 8'((1 << (len + 5)) - 1);
    w.d  = d & mask;
    w.fe = bad_stop;
    w.pe = par_on(pe) && bad_par;
    w.ov = ov;
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int len, input bit s2, input bit pe,
                            input bit po, input bit bad_stop, input bit bad_par);
    logic [7:0] mask;
    mask          = 8'((1 << (len + 5)) - 1);
    bus.data_len  = 2'(len);
    bus.stop2     = s2;
    bus.par_en    = pe;
    bus.par_odd   = po;
    drive_bit(1'b0);
    for (int i = 0; i < len + 5; i++) drive_bit(d[i]);
    if (par_on(pe)) drive_bit((^(d & mask)) ^ po ^ bad_par);
    drive_bit(!bad_stop);
    if (s2) drive_bit(1'b1);
  endtask

  // One frame with rx_ready=1: exactly one word handed over, matching the model.
  task automatic run_frame(input string tag, input logic [7:0] d, input int len, input bit s2,
                           input bit pe, input bit po, input bit bad_stop, input bit bad_par,
                           input int gap_bits);
    word_t e, g;
    e = model(d, len, pe, bad_stop, bad_par, 1'b0);
    send_frame(d, len, s2, pe, po, bad_stop, bad_par);
    check_eq({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check_eq({tag, "_data"}, g.d, e.d);
      check_eq({tag, "_ferr"}, g.fe, e.fe);
      check_eq({tag, "_perr"}, g.pe, e.pe);
      check_eq({tag, "_ovr"}, g.ov, e.ov);
    end
    check_eq({tag, "_vclr"}, bus.rx_valid, 1'b0);
    got_q.delete();
    bus.rx = 1'b1;
    tick(bit_cyc * gap_bits);
  endtask

  initial begin
    word_t e, g;
    int    pend;
    bus.uart_en  = 1'b1;
    bus.data_len = 2'b11;
    bus.stop2    = 1'b0;
    bus.par_en   = 1'b0;
    bus.par_odd  = 1'b0;
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b1;
    set_baud(53);
    resetn = 1'b0;
    tick(4);
    check_eq("rst_valid", bus.rx_valid, 1'b0);
    check_eq("rst_data", bus.rx_data, 8'h00);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_flags", {bus.frame_err, bus.par_err, bus.overrun}, 3'b000);
    resetn = 1'b1;
    tick(4);

    // 8N1 at the nominal divisor
    run_frame("a5", 8'hA5, 3, 0, 0, 0, 0, 0, 1);

    // Short low glitch: false start, no word
    bus.rx = 1'b0;
    tick(100);
    check_eq("glitch_busy", bus.busy, 1'b1);
    tick(200);
    bus.rx = 1'b1;
    tick(2 * bit_cyc);
    check_eq("glitch_idle", bus.busy, 1'b0);
    check_eq("glitch_valid", bus.rx_valid, 1'b0);
    check_eq("glitch_none", got_q.size(), 0);

    set_baud(7);
    run_frame("len5a", 8'h1F, 0, 0, 0, 0, 0, 0, 1);
    run_frame("len5b", 8'h15, 0, 0, 0, 0, 0, 0, 1);
`ifdef UART_RX_PARITY_EN
    run_frame("8e1", 8'h03, 3, 0, 1, 0, 0, 1, 1);
`endif
    run_frame("badstop", 8'h55, 3, 0, 0, 0, 1, 0, 1);
    run_frame("goodstop", 8'h12, 3, 0, 0, 0, 0, 0, 1);

    // Back-to-back frames with the consumer stalled
    bus.rx_ready = 1'b0;
    pend = 0;
    send_frame(8'h11, 3, 0, 0, 0, 0, 0);
    pend++;
    send_frame(8'h22, 3, 0, 0, 0, 0, 0);
    e = model(8'h22, 3, 0, 0, 0, pend > 0);
    bus.rx = 1'b1;
    tick(bit_cyc);
    check_eq("ovr_valid", bus.rx_valid, 1'b1);
    check_eq("ovr_data", bus.rx_data, e.d);
    check_eq("ovr_flag", bus.overrun, e.ov);
    bus.rx_ready = 1'b1;
    tick(1);
    check_eq("ovr_vclr", bus.rx_valid, 1'b0);
    check_eq("ovr_hs", got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check_eq("ovr_hs_data", g.d, e.d);
    end
    got_q.delete();

    // Abort mid-frame keeps the pending word
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 3, 0, 0, 0, 0, 0);
    bus.rx = 1'b1;
    tick(bit_cyc);
    check_eq("pend_data", bus.rx_data, 8'h5A);
    check_eq("pend_ovr", bus.overrun, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    bus.uart_en = 1'b0;
    tick(1);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_valid", bus.rx_valid, 1'b1);
    check_eq("abort_data", bus.rx_data, 8'h5A);
    bus.rx = 1'b1;
    tick(bit_cyc);
    bus.uart_en = 1'b1;
    tick(bit_cyc * 10);
    check_eq("abort_valid2", bus.rx_valid, 1'b1);
    check_eq("abort_none", bus.busy, 1'b0);

    // Reset mid-frame discards everything, next frame received cleanly
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check_eq("mid_busy", bus.busy, 1'b1);
    bus.rx = 1'b1;
    resetn = 1'b0;
    tick(1);
    check_eq("mrst_valid", bus.rx_valid, 1'b0);
    check_eq("mrst_data", bus.rx_data, 8'h00);
    check_eq("mrst_busy", bus.busy, 1'b0);
    check_eq("mrst_flags", {bus.frame_err, bus.par_err, bus.overrun}, 3'b000);
    resetn = 1'b1;
    bus.rx_ready = 1'b1;
    got_q.delete();
    tick(bit_cyc);
    run_frame("post_rst", 8'h3C, 3, 0, 0, 0, 0, 0, 1);

    // Randomized frames over divisor, length, stop bits, parity and line errors
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int bd, len;
      bit s2, pe, po, bs, bp;
      bd  = int'($urandom_range(0, 4));
      len = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      s2  = 1'($urandom);
      pe  = 1'($urandom);
      po  = 1'($urandom);
      bs  = ($urandom_range(0, 3) == 0);
      bp  = ($urandom_range(0, 3) == 0);
      set_baud(bd);
      run_frame($sformatf("rnd%0d", k), d, len, s2, pe, po, bs, bp, 1 + int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
